// File: rtl/maze_dfs_if.sv
// Bundle of the solver's request, memory and path-stream signals.
// Handshake: a path beat transfers on a rising clk edge where path_valid and
// path_ready are both 1; while path_valid=1 and path_ready=0 the producer holds
// path_row/path_col stable and keeps path_valid high; the consumer may change
// path_ready freely. mem_rdata answers a mem_rd strobe one cycle later.
interface maze_dfs_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    logic                   start;
    logic [ROW_W-1:0]       src_row;
    logic [COL_W-1:0]       src_col;
    logic [ROW_W-1:0]       tgt_row;
    logic [COL_W-1:0]       tgt_col;
    logic [ROW_W+COL_W-1:0] mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   mem_rdata;
    logic                   path_valid;
    logic                   path_ready;
    logic [ROW_W-1:0]       path_row;
    logic [COL_W-1:0]       path_col;
    logic                   busy;
    logic                   done;
    logic                   fail;
    logic                   ovf;
    logic [ROW_W+COL_W:0]   path_len;

    modport master (
        output start, src_row, src_col, tgt_row, tgt_col, mem_rdata, path_ready,
        input  mem_addr, mem_rd, mem_wr, path_valid, path_row, path_col,
        input  busy, done, fail, ovf, path_len
    );

    modport slave (
        input  start, src_row, src_col, tgt_row, tgt_col, mem_rdata, path_ready,
        output mem_addr, mem_rd, mem_wr, path_valid, path_row, path_col,
        output busy, done, fail, ovf, path_len
    );
endinterface

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver: walks a 2-D grid stored in an external 1-bit
// memory (1 = wall or visited), marks cells as it enters them, keeps the
// current path on an internal stack and streams it out source-first.
module maze_dfs_ctrl #(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int STACK_DEPTH = 64
) (
    input  logic        clk,
    input  logic        RST,
    maze_dfs_if.slave   bus,
    output logic [3:0]  dbg_state
);
    localparam int AW    = ROW_W + COL_W;
    localparam int LEN_W = AW + 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, INIT, CHECK, WAIT, MOVE, NEXTDIR, BACK, OUT, DONE, FAIL
    } state_t;

    state_t state, state_nx;

    logic [ROW_W-1:0] tgt_row, pos_row, nb_row;
    logic [COL_W-1:0] tgt_col, pos_col, nb_col;
    logic [1:0]       dir;
    logic [SP_W-1:0]  sp, idx;
    logic             ovf_r;
    logic             nb_in, nb_is_tgt, stack_full, beat_xfer;
    logic [IDX_W-1:0] push_i, top_i, out_i;

    logic [ROW_W-1:0] stk_row [STACK_DEPTH];
    logic [COL_W-1:0] stk_col [STACK_DEPTH];
    logic [1:0]       stk_dir [STACK_DEPTH];

    assign push_i     = IDX_W'(sp);
    assign top_i      = IDX_W'(sp - SP_W'(1));
    assign out_i      = IDX_W'(idx);
    assign stack_full = (sp == SP_W'(STACK_DEPTH));
    assign nb_is_tgt  = (nb_row == tgt_row) && (nb_col == tgt_col);
    assign beat_xfer  = (state == OUT) && bus.path_ready;
    assign dbg_state  = state;

    // Neighbour of pos in direction dir; nb_in=0 when it falls off the grid.
    always_comb begin
        nb_row = pos_row;
        nb_col = pos_col;
        nb_in  = 1'b1;
        case (dir)
            2'd0: if (pos_row == '0) nb_in = 1'b0; else nb_row = pos_row - ROW_W'(1);
            2'd1: if (pos_col == '1) nb_in = 1'b0; else nb_col = pos_col + COL_W'(1);
            2'd2: if (pos_row == '1) nb_in = 1'b0; else nb_row = pos_row + ROW_W'(1);
            default: if (pos_col == '0) nb_in = 1'b0; else nb_col = pos_col - COL_W'(1);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decision.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, FAIL: if (bus.start) state_nx = INIT;
            INIT:    state_nx = ((pos_row == tgt_row) && (pos_col == tgt_col)) ? OUT : CHECK;
            CHECK:   state_nx = nb_in ? WAIT : NEXTDIR;
            WAIT: begin
                if (bus.mem_rdata)   state_nx = NEXTDIR;
                else if (stack_full) state_nx = FAIL;
                else                 state_nx = MOVE;
            end
            MOVE:    state_nx = nb_is_tgt ? OUT : CHECK;
            NEXTDIR: state_nx = (dir == 2'd3) ? BACK : CHECK;
            BACK:    state_nx = (sp == '0) ? FAIL : NEXTDIR;
            OUT:     if (beat_xfer && (idx == sp)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs decoded from state and registers.
    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.path_valid = 1'b0;
        bus.path_row   = '0;
        bus.path_col   = '0;
        bus.path_len   = '0;
        bus.busy       = !((state == IDLE) || (state == DONE) || (state == FAIL));
        bus.done       = (state == DONE);
        bus.fail       = (state == FAIL);
        bus.ovf        = ovf_r;
        case (state)
            INIT: begin
                bus.mem_wr   = 1'b1;
                bus.mem_addr = {pos_row, pos_col};
            end
            CHECK: begin
                if (nb_in) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = {nb_row, nb_col};
                end
            end
            MOVE: begin
                bus.mem_wr   = 1'b1;
                bus.mem_addr = {nb_row, nb_col};
            end
            OUT: begin
                bus.path_valid = 1'b1;
                if (idx < sp) begin
                    bus.path_row = stk_row[out_i];
                    bus.path_col = stk_col[out_i];
                end else begin
                    bus.path_row = tgt_row;
                    bus.path_col = tgt_col;
                end
            end
            DONE: bus.path_len = LEN_W'(sp) + LEN_W'(1);
            default: ;
        endcase
    end

    // Position, direction, stack pointer, output index and overflow flag.
    always_ff @(posedge clk) begin
        if (RST) begin
            tgt_row <= '0;
            tgt_col <= '0;
            pos_row <= '0;
            pos_col <= '0;
            dir     <= '0;
            sp      <= '0;
            idx     <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (bus.start) begin
                        tgt_row <= bus.tgt_row;
                        tgt_col <= bus.tgt_col;
                        pos_row <= bus.src_row;
                        pos_col <= bus.src_col;
                        dir     <= '0;
                        sp      <= '0;
                        idx     <= '0;
                        ovf_r   <= 1'b0;
                    end
                end
                WAIT: if (!bus.mem_rdata && stack_full) ovf_r <= 1'b1;
                MOVE: begin
                    sp      <= sp + SP_W'(1);
                    pos_row <= nb_row;
                    pos_col <= nb_col;
                    dir     <= '0;
                end
                NEXTDIR: if (dir != 2'd3) dir <= dir + 2'd1;
                BACK: begin
                    if (sp != '0) begin
                        sp      <= sp - SP_W'(1);
                        pos_row <= stk_row[top_i];
                        pos_col <= stk_col[top_i];
                        dir     <= stk_dir[top_i];
                    end
                end
                OUT: if (beat_xfer && (idx != sp)) idx <= idx + SP_W'(1);
                default: ;
            endcase
        end
    end

    // Path stack push; contents need no reset since sp bounds every read.
    always_ff @(posedge clk) begin
        if (!RST && (state == MOVE)) begin
            stk_row[push_i] <= pos_row;
            stk_col[push_i] <= pos_col;
            stk_dir[push_i] <= dir;
        end
    end
endmodule

// File: doc/maze_dfs_ctrl.md
MAZE_DFS_CTRL -- requirements
Module: maze_dfs_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ROW_W, 4, row index width; COL_W, 4, column index width; STACK_DEPTH, 64, path-stack entries (1..2**(ROW_W+COL_W)).
REQ-002 Ports (name direction width meaning): clk in 1 clock; RST in 1 synchronous active-high reset; one clock; reset is synchronous and active-high.
REQ-003 start in 1 begin solve; src_row/tgt_row in ROW_W, src_col/tgt_col in COL_W, source and target cells, sampled when start is accepted.
REQ-004 mem_addr out ROW_W+COL_W {row,col}; mem_rd out 1 read strobe; mem_wr out 1 write-1 (mark visited) strobe; mem_rdata in 1 (1 = wall/visited), valid the cycle after mem_rd.
REQ-005 path_valid out 1, path_ready in 1, path_row out ROW_W, path_col out COL_W: path stream; busy, done, fail, ovf out 1; path_len out ROW_W+COL_W+1.

Function
REQ-006 The design SHALL be a Moore FSM with states IDLE, INIT, CHECK, WAIT, MOVE, NEXTDIR, BACK, OUT, DONE, FAIL; mem_*, path_*, busy, done, fail and ovf decode from state and registers only.
REQ-007 IDLE/DONE/FAIL + start=1: latch src/tgt, pos<=src, dir<=0, sp<=0, ovf<=0 -> INIT.
REQ-008 INIT: mem_wr=1, mem_addr=src; -> OUT if src==tgt, else CHECK.
REQ-009 Direction order: dir 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1); no wrap-around.
REQ-010 CHECK: neighbour outside grid (row 0 up, row 2**ROW_W-1 down, col 0 left, col 2**COL_W-1 right) -> NEXTDIR with no memory access; else mem_rd=1, mem_addr=neighbour -> WAIT.
REQ-011 WAIT: mem_rdata=1 -> NEXTDIR; mem_rdata=0 and sp==STACK_DEPTH -> FAIL with ovf<=1; else -> MOVE.
REQ-012 MOVE: push {pos,dir}, sp+1; pos<=neighbour; dir<=0; mem_wr=1 at neighbour; -> OUT if neighbour==tgt, else CHECK.
REQ-013 NEXTDIR: dir==3 -> BACK; else dir+1 -> CHECK.
REQ-014 BACK: sp==0 -> FAIL (ovf stays 0); else pop top, sp-1, pos/dir<=popped entry -> NEXTDIR (resume at next direction).
REQ-015 OUT: path_valid=1; beat i (0..sp) = stack[i] for i<sp, tgt for i==sp, emitted source-first; index advances only on path_valid&path_ready; data held stable while ready=0; last beat accepted -> DONE.
REQ-016 DONE: done=1, path_len=sp+1, held until next start. FAIL: fail=1, held until next start; path_len=0.
REQ-017 busy=1 in every state except IDLE, DONE, FAIL; start ignored while busy.
REQ-018 Stack SHALL be a register array indexable from bottom (for OUT) and top (for BACK); sp width clog2(STACK_DEPTH+1).

Reset
REQ-019 RST=1 at a clk edge SHALL force IDLE, sp=0, dir=0, pos=0, index=0, ovf=0, regardless of state (including mid-OUT); outputs all 0 the following cycle.
REQ-020 Visited marks in external memory are not cleared by this block; clearing between solves is the system's job.

Verification
REQ-021 ROW_W=COL_W=2, empty maze, src (0,0), tgt (0,3), ready=1 -> path beats (0,0),(0,1),(0,2),(0,3), done=1, path_len=4, fail=0.
REQ-022 Same grid, walls at (0,1) and (1,0), src (0,0), tgt (3,3) -> BACK with sp==0 reached, fail=1, ovf=0, no path_valid.
REQ-023 src==tgt=(2,1) -> one mem_wr at (2,1), single beat (2,1), path_len=1, done=1.
REQ-024 Case of REQ-021 with path_ready=0 for 5 cycles on beat 1 -> path_valid stays 1, path_row/col stay (0,1), no beat lost or duplicated.
REQ-025 STACK_DEPTH=2, empty 4x4, src (0,0), tgt (3,3) -> third push attempt -> fail=1, ovf=1.
REQ-026 RST pulse during OUT beat 2 -> next cycle IDLE, path_valid=0, busy=0; new start solves normally.
